alu_driver: RTL and testbench



---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_rsp_fifo.sv | 48 ++++
 rtl/alu_driver.sv | 100 ++++++++++
 tb/tb_alu_driver.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU op encoding and the default-width response record.
package alu_pkg;

  localparam int ALU_W     = 32;
  localparam int ALU_TAG_W = 4;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } op_t;

  typedef struct packed {
    logic [ALU_W-1:0]     data;
    op_t                  op;
    logic [ALU_TAG_W-1:0] tag;
  } alu_rsp_t;

endpackage

// File: rtl/alu_rsp_fifo.sv
// Show-ahead synchronous FIFO holding captured ALU responses; count feeds the credit logic.
module alu_rsp_fifo #(
  parameter int W     = 38,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          full, do_push, do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;

  // Credit upstream should make this impossible; a hit means the credit math broke.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: rtl/alu_driver.sv
// Drives registered operands into a fixed-latency ALU and returns tagged results in order.
module alu_driver
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [1:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_s,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [1:0]       rsp_op,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  localparam int STAGES = LATENCY;
  localparam int CW     = $clog2(DEPTH+1);
  localparam int OW     = $clog2(DEPTH+LATENCY+2);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    op_t              op;
    logic [TAG_W-1:0] tag;
  } ent_t;

  logic [STAGES:0]            vld_pipe;
  logic [STAGES:0][1:0]       op_pipe;
  logic [STAGES:0][TAG_W-1:0] tag_pipe;
  logic                       accept, pop, empty;
  logic [CW-1:0]              fifo_cnt;
  logic [OW-1:0]              n_fly, outstanding;
  ent_t                       fifo_din, fifo_dout;

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      vld_pipe <= '0;
    end else begin
      if (accept) begin
        alu_a  <= req_a;
        alu_b  <= req_b;
        alu_op <= req_op;
      end
      vld_pipe <= {vld_pipe[STAGES-1:0], accept};
    end
  end

  // Side-band rides alongside the valid bits; only valid slots are ever consumed.
  always_ff @(posedge clk) begin
    op_pipe  <= {op_pipe[STAGES-1:0], req_op};
    tag_pipe <= {tag_pipe[STAGES-1:0], req_tag};
  end

  assign fifo_din = '{data: alu_s, op: op_t'(op_pipe[STAGES]), tag: tag_pipe[STAGES]};

  alu_rsp_fifo #(.W($bits(ent_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_pipe[STAGES]),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (empty),
    .count (fifo_cnt)
  );

  always_comb begin
    n_fly = '0;
    for (int i = 0; i <= STAGES; i++) n_fly = n_fly + OW'(vld_pipe[i]);
  end

  assign outstanding = n_fly + OW'(fifo_cnt);
  assign req_ready   = !rst && (outstanding < OW'(DEPTH));
  assign busy        = (outstanding != '0);

  assign rsp_valid = !empty;
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_data  = fifo_dout.data;
  assign rsp_op    = fifo_dout.op;
  assign rsp_tag   = fifo_dout.tag;

endmodule

// File: tb/tb_alu_driver.sv
// Random + directed bench for alu_driver at LATENCY 1 and 3 against a transaction-level model.
module tb_alu_driver;
  import alu_pkg::*;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic [W-1:0]  req_a = '0, req_b = '0;
  logic [1:0]    req_op = '0;
  logic [TW-1:0] req_tag = '0;
  logic          rsp_ready = 1'b1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    alu_rsp_t r;
    int       rdy;
  } exp_t;

  for (genvar gi = 0; gi < 2; gi++) begin : g
    localparam int L = (gi == 0) ? 1 : 3;

    logic          req_ready, rsp_valid, busy;
    logic [W-1:0]  alu_a, alu_b, alu_s, rsp_data;
    logic [1:0]    alu_op, rsp_op;
    logic [TW-1:0] rsp_tag;
    logic [W-1:0]  sp [L];
    exp_t          q[$];
    int            nacc = 0;

    alu_driver #(.WIDTH(W), .LATENCY(L), .DEPTH(D), .TAG_W(TW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_s(alu_s),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_op(rsp_op), .rsp_tag(rsp_tag),
      .busy(busy)
    );

    // ALU stand-in: samples operands every edge, result visible L cycles later.
    always @(posedge clk) begin
      case (alu_op)
        2'b00:   sp[0] <= alu_a + alu_b;
        2'b01:   sp[0] <= alu_a - alu_b;
        2'b10:   sp[0] <= alu_a & alu_b;
        default: sp[0] <= alu_a | alu_b;
      endcase
      for (int i = 1; i < L; i++) sp[i] <= sp[i-1];
    end
    assign alu_s = sp[L-1];

    // Model: queue of accepted ops; head is due LATENCY+1 edges after its accept edge.
    always @(negedge clk) begin
      logic ev;
      exp_t e;
      ev = (q.size() > 0) && (q[0].rdy <= cyc);
      if (cyc > 0) begin
        chk($sformatf("L%0d.req_ready", L), req_ready, (!rst && q.size() < D));
        chk($sformatf("L%0d.busy", L), busy, (q.size() != 0));
        chk($sformatf("L%0d.rsp_valid", L), rsp_valid, ev);
        if (ev && rsp_valid) begin
          chk($sformatf("L%0d.rsp_data", L), rsp_data, q[0].r.data);
          chk($sformatf("L%0d.rsp_op", L), rsp_op, q[0].r.op);
          chk($sformatf("L%0d.rsp_tag", L), rsp_tag, q[0].r.tag);
        end
      end
      if (rst) q.delete();
      else begin
        if (ev && rsp_ready) void'(q.pop_front());
        if (req_valid && req_ready) begin
          case (req_op)
            ALU_ADD: e.r.data = req_a + req_b;
            ALU_SUB: e.r.data = req_a - req_b;
            ALU_AND: e.r.data = req_a & req_b;
            default: e.r.data = req_a | req_b;
          endcase
          e.r.op  = op_t'(req_op);
          e.r.tag = req_tag;
          e.rdy   = cyc + 1 + L + 1;
          q.push_back(e);
          nacc++;
        end
      end
    end
  end

  task automatic put(input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [1:0] op, input logic [TW-1:0] tag);
    req_valid = 1'b1;
    req_a = a; req_b = b; req_op = op; req_tag = tag;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset.alu_a", g[0].alu_a, 0);
    chk("reset.alu_b", g[0].alu_b, 0);
    chk("reset.alu_op", g[1].alu_op, 0);
    chk("reset.rsp_valid", g[1].rsp_valid, 0);
    @(posedge clk); #1;

    put(5, 3, 2'b00, 1);
    idle(6);
    chk("single.busy", g[0].busy, 0);

    put(3, 5, 2'b01, 2);
    put(32'hF0F0, 32'h0FF0, 2'b10, 3);
    put(32'hF000, 32'h000F, 2'b11, 4);
    idle(8);

    for (int i = 0; i < 4; i++) put($urandom, $urandom, 2'($urandom), 4'(i + 8));
    idle(8);

    // Backpressure: consumer stalled, requester keeps pushing.
    rsp_ready = 1'b0;
    n0 = g[0].nacc;
    for (int i = 0; i < 8; i++) put($urandom, $urandom, 2'($urandom), 4'(i));
    chk("bp.accepts", g[0].nacc - n0, 4);
    chk("bp.req_ready", g[0].req_ready, 0);
    req_valid = 1'b0;
    idle(3);
    rsp_ready = 1'b1;
    idle(10);

    put(1, 2, 2'b00, 5);
    put(7, 9, 2'b00, 6);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(6);
    chk("rst.busy", g[0].busy, 0);
    chk("rst.req_ready", g[1].req_ready, 1);
    put(10, 7, 2'b01, 9);
    idle(8);

    for (int i = 0; i < 800; i++) begin
      req_valid = ($urandom_range(0, 99) < 70);
      req_a     = $urandom;
      req_b     = $urandom;
      req_op    = 2'($urandom);
      req_tag   = 4'($urandom);
      rsp_ready = ($urandom_range(0, 99) < 60);
      rst       = ($urandom_range(0, 199) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    rsp_ready = 1'b1;
    idle(20);
    chk("drain.busy0", g[0].busy, 0);
    chk("drain.busy1", g[1].busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
